bit_serial_adder: RTL and testbench
===================================

Name: bit_serial_adder

Overview:
- Sequential front end that drives a single `full_adder` cell one bit per clock, LSB first, to produce WIDTH-bit add/subtract results.
- Holds the operand shift registers, the carry flip-flop and the result shift register.
- Reports carry, signed overflow and zero flags.
- Area-minimal alternative to the ripple adder in the 8-bit ALU datapath. Fed by the ALU operand registers; its results go to the ALU result mux.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2); bit counter width = clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- sub  input  1  0 = A+B, 1 = A−B; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when results become valid
- result  output  WIDTH  sum/difference; held until the next accepted start
- cout  output  1  final carry out (for sub: 1 = no borrow)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  result == 0

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - busy, done, result, cout, overflow, zero all 0.
  - Shift registers, carry flip-flop and counter cleared.
- FSM states: IDLE, RUN, DONE. Unused encodings go to IDLE.
- IDLE:
  - On start=1: load A_sr ← a; B_sr ← sub ? ~b : b; carry ← sub; cnt ← 0; go to RUN.
  - On start=0: stay in IDLE; outputs hold.
- RUN (one bit per cycle):
  - full_adder(A_sr[0], B_sr[0], carry) produces s and c.
  - result_sr ← {s, result_sr[WIDTH-1:1]}.
  - A_sr and B_sr shift right by one; carry ← c; cnt ← cnt+1.
  - When cnt == WIDTH-1: capture overflow ← carry ^ c and cout ← c; go to DONE.
- DONE (exactly one cycle):
  - done=1. result, cout, overflow are valid.
  - zero = (result == 0), registered on the RUN→DONE edge so it is valid with done.
  - Return to IDLE.
- Latency: start sampled at edge k → busy high for cycles k+1 … k+WIDTH → done high during cycle k+WIDTH+1. For WIDTH=8 this is 9 cycles from the start edge to done.
- result, cout, overflow and zero hold their values after DONE until the next accepted start.
  - result may shift visibly during RUN. Consumers use it only when done=1 or in IDLE after done.
- start while in RUN or DONE: ignored, no queuing. Operand inputs are also ignored outside IDLE.
- start held high continuously: a new operation is accepted each time the FSM is in IDLE, giving a back-to-back period of WIDTH+2 cycles.
- rst asserted mid-operation: immediate abort to the reset values. done must not pulse for the aborted operation.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1; cout=1 means A ≥ B (unsigned).

Decomposition:
- Shared package `alu_pkg`:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default WIDTH=8 constant
  - op constant OP_ADD=1'b0, OP_SUB=1'b1
- Sub-module: one instance of the existing `full_adder` (a, b, cin → sum, cout) for the bit cell. No other sub-modules; FSM, counter and shift registers stay in `bit_serial_adder`.

Test Plan:
- Add: a=8'h25, b=8'h1A, sub=0, start 1 cycle → done in cycle k+9; result=8'h3F, cout=0, overflow=0, zero=0; busy high for exactly 8 cycles.
- Signed overflow: a=8'h7F, b=8'h01, sub=0 → result=8'h80, cout=0, overflow=1, zero=0.
- Wrap to zero: a=8'hFF, b=8'h01, sub=0 → result=8'h00, cout=1, overflow=0, zero=1.
- Subtract with borrow: a=8'h05, b=8'h07, sub=1 → result=8'hFE, cout=0, overflow=0. Then a=8'h80, b=8'h01, sub=1 → result=8'h7F, cout=1, overflow=1.
- Start while busy: start a=8'h10, b=8'h20; pulse start with a=8'hAA at cycle k+3 → single done, result=8'h30. Start held high continuously → done pulses every 10 cycles.
- Reset mid-operation: assert rst at cycle k+4 of a run → all outputs 0 immediately, no done pulse. After release, a=8'h01, b=8'h01 → result=8'h02 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath: FSM encodings, default width, op codes.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract unit: one full_adder cell driven LSB first,
// one bit per clock, with carry, signed overflow and zero flags.
module bit_serial_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] result_next;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign last_bit    = (cnt == CW'(WIDTH - 1));
  assign result_next = {fa_s, result[WIDTH-1:1]};

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // FSM, operand/result shift registers, carry flop and flag capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            // subtraction is A + ~B + 1: invert B and seed the carry with 1
            b_sr  <= (sub == OP_SUB) ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          result <= result_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            // carry still holds the carry into the MSB on this cycle
            overflow <= carry ^ fa_c;
            cout     <= fa_c;
            zero     <= (result_next == '0);
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : bit_serial_adder

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: vector table, random ops,
// and hand-written multi-cycle corner cases, checked via a scoreboard.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    exp_t         e;
  } vec_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent arithmetic model
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t         e;
    logic [W-1:0] yy;
    logic [W:0]   t;
    yy  = s ? ~y : y;
    t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    e.r = t[W-1:0];
    e.c = t[W];
    e.v = (x[W-1] == yy[W-1]) && (e.r[W-1] != x[W-1]);
    e.z = (e.r == '0);
    return e;
  endfunction

  // Scoreboard: every done pulse pops and checks one expectation
  int          done_cnt   = 0;
  int unsigned last_done  = 0;
  bit          have_last  = 1'b0;
  bit          chk_period = 1'b0;
  exp_t        got_e;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        got_e = sbq.pop_front();
        check("result",   32'(result),   32'(got_e.r));
        check("cout",     32'(cout),     32'(got_e.c));
        check("overflow", 32'(overflow), 32'(got_e.v));
        check("zero",     32'(zero),     32'(got_e.z));
      end
      if (chk_period && have_last) check("b2b_period", cyc - last_done, W + 2);
      last_done = cyc;
      have_last = 1'b1;
    end
  end

  task automatic wait_idle();
    int i = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (i >= 100) check("idle_timeout", 32'(i), 32'(0));
  endtask

  // Issue one op with a 1-cycle start pulse, optionally checking latency/busy length
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input exp_t e, input bit chk_lat);
    int lat   = 0;
    int busyc = 0;
    bit seen  = 1'b0;
    wait_idle();
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busyc++;
    end
    if (!seen) check("done_timeout", 32'(lat), 32'(W + 1));
    else if (chk_lat) begin
      check("latency",     32'(lat),   32'(W + 1));
      check("busy_cycles", 32'(busyc), 32'(W));
    end
  endtask

  vec_t vecs[8];

  initial begin
    int d0;
    int i;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    vecs[0] = '{8'h25, 8'h1A, 1'b0, '{8'h3F, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}};
    vecs[3] = '{8'h05, 8'h07, 1'b1, '{8'hFE, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{8'h80, 8'h01, 1'b1, '{8'h7F, 1'b1, 1'b1, 1'b0}};
    vecs[5] = '{8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b1}};
    vecs[6] = '{8'h80, 8'h80, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1}};
    vecs[7] = '{8'h7F, 8'hFF, 1'b1, '{8'h80, 1'b0, 1'b1, 1'b0}};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_done",     32'(done),     32'(0));
    check("rst_result",   32'(result),   32'(0));
    check("rst_cout",     32'(cout),     32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_zero",     32'(zero),     32'(0));
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 8; k++)
      run_op(vecs[k].a, vecs[k].b, vecs[k].sub, vecs[k].e, 1'b1);

    for (int k = 0; k < 8; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(1, 0));
      run_op(ra, rb, rs, model(ra, rb, rs), 1'b0);
    end

    // Start pulsed while running must be ignored
    wait_idle();
    @(negedge clk);
    d0 = done_cnt;
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    sbq.push_back('{8'h30, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 a = 8'hAA; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (25) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'(1));

    // Start held high: three accepted ops, done every W+2 cycles
    wait_idle();
    @(negedge clk);
    d0 = done_cnt;
    a = 8'h03; b = 8'h04; sub = 1'b0;
    for (int k = 0; k < 3; k++) sbq.push_back('{8'h07, 1'b0, 1'b0, 1'b0});
    have_last = 1'b0;
    chk_period = 1'b1;
    start = 1'b1;
    repeat (21) @(posedge clk);
    #1 start = 1'b0;
    i = 0;
    while (done_cnt < d0 + 3 && i < 40) begin
      @(posedge clk);
      i++;
    end
    repeat (15) @(negedge clk);
    chk_period = 1'b0;
    check("b2b_done_count", 32'(done_cnt - d0), 32'(3));

    // Reset mid-operation: immediate clear, no done for the aborted op
    wait_idle();
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check("abort_busy",     32'(busy),     32'(0));
    check("abort_done",     32'(done),     32'(0));
    check("abort_result",   32'(result),   32'(0));
    check("abort_cout",     32'(cout),     32'(0));
    check("abort_overflow", 32'(overflow), 32'(0));
    check("abort_zero",     32'(zero),     32'(0));
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (15) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt - d0), 32'(0));
    run_op(8'h01, 8'h01, 1'b0, '{8'h02, 1'b0, 1'b0, 1'b0}, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bit_serial_adder
